alu_op_sequencer: RTL

Controller that sequences the bit-serial ALU/register-file datapath for one micro-op at a time. It accepts a decoded micro-op over a valid/ready handshake, latches it, and drives the ALU control and enable lines. It stalls the ALU while a serial external operand is unavailable and repeats the operation for multi-pass ops such as single-step shifts. It sits between the instruction decoder and the ALU.

---
 rtl/alu_op_sequencer_pkg.sv | 45 ++++
 rtl/alu_op_sequencer_if.sv | 47 ++++
 rtl/alu_seq_perf_counters.sv | 25 ++
 rtl/alu_op_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants, state encoding and micro-op payload for the ALU op sequencer.
// Optional performance counters are enabled with `define ALU_SEQ_PERF_EN.
package alu_op_sequencer_pkg;

   localparam int unsigned LOG2_NR   = 3;
   localparam int unsigned OP_BITS   = 3;
   localparam int unsigned PASS_BITS = 3;
   localparam int unsigned NSHIFT    = 2;
   localparam int unsigned REG_BITS  = 8;
   localparam int unsigned PERF_BITS = 16;

   // ALU cycles per pass: one register (single) or a register pair
   localparam int unsigned CYCLES_SINGLE = REG_BITS / NSHIFT;
   localparam int unsigned CYCLES_PAIR   = (2 * REG_BITS) / NSHIFT;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(0);
   localparam logic [OP_BITS-1:0] OP_ADC = OP_BITS'(1);
   localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(2);
   localparam logic [OP_BITS-1:0] OP_SBC = OP_BITS'(3);
   localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(4);
   localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(5);
   localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(6);
   localparam logic [OP_BITS-1:0] OP_SHR = OP_BITS'(7);

   typedef struct packed {
      logic [OP_BITS-1:0] op;
      logic [LOG2_NR-1:0] reg1;
      logic [LOG2_NR-1:0] reg2;
      logic               pair;
      logic               ext2;
      logic               update_reg1;
      logic               update_flags;
   } uop_t;

   function automatic int unsigned pass_cycles(input logic pair);
      return pair ? CYCLES_PAIR : CYCLES_SINGLE;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Decoder/ALU-facing signal bundle of the ALU op sequencer.
interface alu_op_sequencer_if;
   import alu_op_sequencer_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic [OP_BITS-1:0]   req_op;
   logic [LOG2_NR-1:0]   req_reg1;
   logic [LOG2_NR-1:0]   req_reg2;
   logic                 req_pair;
   logic                 req_ext2;
   logic                 req_update_reg1;
   logic                 req_update_flags;
   logic [PASS_BITS-1:0] req_passes;
   logic                 ext_valid;
   logic                 ext_ready;
   logic                 alu_op_done;
   logic                 alu_regfile_en;
   logic                 alu_advance;
   logic [OP_BITS-1:0]   alu_operation;
   logic [LOG2_NR-1:0]   alu_reg1;
   logic [LOG2_NR-1:0]   alu_reg2;
   logic                 alu_pair_op;
   logic                 alu_external_arg2;
   logic                 alu_update_reg1;
   logic                 alu_update_carry_flags;
   logic                 alu_update_other_flags;
   logic                 busy;
   logic                 done;

   modport master (
      output req_valid, req_op, req_reg1, req_reg2, req_pair, req_ext2,
             req_update_reg1, req_update_flags, req_passes, ext_valid, alu_op_done,
      input  req_ready, ext_ready, alu_regfile_en, alu_advance, alu_operation,
             alu_reg1, alu_reg2, alu_pair_op, alu_external_arg2, alu_update_reg1,
             alu_update_carry_flags, alu_update_other_flags, busy, done
   );

   modport slave (
      input  req_valid, req_op, req_reg1, req_reg2, req_pair, req_ext2,
             req_update_reg1, req_update_flags, req_passes, ext_valid, alu_op_done,
      output req_ready, ext_ready, alu_regfile_en, alu_advance, alu_operation,
             alu_reg1, alu_reg2, alu_pair_op, alu_external_arg2, alu_update_reg1,
             alu_update_carry_flags, alu_update_other_flags, busy, done
   );

endinterface

// File: rtl/alu_seq_perf_counters.sv
// Saturating counters of completed micro-ops and RUN stall cycles.
module alu_seq_perf_counters
   import alu_op_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc_ops,
   input  logic                 inc_stalls,
   output logic [PERF_BITS-1:0] perf_ops,
   output logic [PERF_BITS-1:0] perf_stalls
);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_ops    <= '0;
         perf_stalls <= '0;
      end else begin
         if (inc_ops && (perf_ops != '1))
            perf_ops <= perf_ops + PERF_BITS'(1);
         if (inc_stalls && (perf_stalls != '1))
            perf_stalls <= perf_stalls + PERF_BITS'(1);
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the bit-serial ALU for one latched micro-op, with stalls and repeat passes.
// `define ALU_SEQ_PERF_EN adds perf_ops/perf_stalls saturating counters.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   alu_op_sequencer_if.slave    bus
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [PERF_BITS-1:0] perf_ops,
   output logic [PERF_BITS-1:0] perf_stalls
`endif
);

   seq_state_e           state_q, state_d;
   uop_t                 uop_q;
   logic [PASS_BITS-1:0] pass_q, pass_d;
   logic                 load_c;
   logic                 go_c;
   logic                 ready_c, busy_c, done_c, ext_ready_c, flags_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
      end
   end

   // Micro-op fields stay frozen from acceptance until the next acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         uop_q <= '0;
      end else if (load_c) begin
         uop_q.op           <= bus.req_op;
         uop_q.reg1         <= bus.req_reg1;
         uop_q.reg2         <= bus.req_reg2;
         uop_q.pair         <= bus.req_pair;
         uop_q.ext2         <= bus.req_ext2;
         uop_q.update_reg1  <= bus.req_update_reg1;
         uop_q.update_flags <= bus.req_update_flags;
      end
   end

   always_comb begin
      state_d     = state_q;
      pass_d      = pass_q;
      load_c      = 1'b0;
      go_c        = 1'b0;
      ready_c     = 1'b0;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      ext_ready_c = 1'b0;
      flags_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            if (bus.req_valid) begin
               load_c  = 1'b1;
               pass_d  = bus.req_passes;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy_c      = 1'b1;
            go_c        = !uop_q.ext2 || bus.ext_valid;
            ext_ready_c = go_c && uop_q.ext2;
            // Flags only follow the final pass of a repeated op
            flags_c     = uop_q.update_flags && (pass_q == '0);
            if (go_c && bus.alu_op_done) begin
               if (pass_q != '0)
                  pass_d = pass_q - PASS_BITS'(1);
               else
                  state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.req_ready              = ready_c;
   assign bus.busy                   = busy_c;
   assign bus.done                   = done_c;
   assign bus.alu_advance            = go_c;
   assign bus.alu_regfile_en         = go_c;
   assign bus.ext_ready              = ext_ready_c;
   assign bus.alu_update_carry_flags = flags_c;
   assign bus.alu_update_other_flags = flags_c;
   assign bus.alu_operation          = uop_q.op;
   assign bus.alu_reg1               = uop_q.reg1;
   assign bus.alu_reg2               = uop_q.reg2;
   assign bus.alu_pair_op            = uop_q.pair;
   assign bus.alu_external_arg2      = uop_q.ext2;
   assign bus.alu_update_reg1        = uop_q.update_reg1;

`ifdef ALU_SEQ_PERF_EN
   alu_seq_perf_counters u_perf (
      .clk         (clk),
      .reset       (reset),
      .inc_ops     (done_c),
      .inc_stalls  (busy_c && !go_c),
      .perf_ops    (perf_ops),
      .perf_stalls (perf_stalls)
   );
`endif

endmodule
